hilo_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that owns the Hi/Lo register pair for the multi-cycle datapath.
- Executes MULT, MULTU, DIV and DIVU using one shift-add or restoring-divide step per clock.
- Accepts direct Hi/Lo writes (MTHI/MTLO).
- Exposes a start/busy/done handshake so the control unit can stall on MFHI/MFLO.
- hi and lo feed the ALU A-mux inputs.

---
 rtl/hilo_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Iterative multiply/divide unit that owns the Hi/Lo register pair.
// MULT/MULTU use one shift-add step per clock and DIV/DIVU use one
// restoring-divide step per clock. Both work on operand magnitudes, and the
// sign correction happens in a final FIX cycle. MTHI/MTLO write Hi/Lo directly
// while the unit is idle.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        begin an operation (only honoured in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         multiplicand/dividend, multiplier/divisor
//   mthi, mtlo   write wdata into hi / lo (only in IDLE, and only without start)
//   wdata        data for mthi/mtlo
//   busy         operation in progress
//   done         one-cycle pulse once hi/lo hold the result
//   div_by_zero  sticky flag for a zero divisor, cleared by the next start
//   hi, lo       Hi/Lo registers
// -----------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_ZDIV = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);

    // Two's complement negation helpers
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   acc_q, acc_d;       // running high product / partial remainder
    logic [WIDTH-1:0]   work_q, work_d;     // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand magnitude / divisor magnitude
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;   // negate product or quotient in FIX
    logic               neg_r_q, neg_r_d;   // negate remainder in FIX

    // Operand magnitudes; the MIN value maps onto 2^(WIDTH-1) as an unsigned number
    logic               is_signed_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic               div_zero_s;

    assign is_signed_s = ~op[0];
    assign a_neg_s     = is_signed_s & a[WIDTH-1];
    assign b_neg_s     = is_signed_s & b[WIDTH-1];
    assign a_mag_s     = a_neg_s ? neg_w(a) : a;
    assign b_mag_s     = b_neg_s ? neg_w(b) : b;
    assign div_zero_s  = op[1] & (b == ZERO_W);

    // Shift-add step: add the multiplicand when the current multiplier bit is set,
    // then shift {carry, acc, work} right by one
    logic [WIDTH:0]     sum_s;
    assign sum_s = {1'b0, acc_q} + (work_q[0] ? {1'b0, mcand_q} : {1'b0, ZERO_W});

    // Restoring-divide step: bring in the next dividend bit and try subtracting
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH+1:0]   diff_s;
    logic               borrow_s;
    logic               unused_diff_s;
    assign rem_sh_s      = {acc_q, work_q[WIDTH-1]};
    assign diff_s        = {1'b0, rem_sh_s} - {2'b00, mcand_q};
    assign borrow_s      = diff_s[WIDTH+1];
    // A successful subtraction always leaves a value below the divisor
    assign unused_diff_s = diff_s[WIDTH];

    // Sign-corrected results written back in FIX
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;
    assign prod_s     = {acc_q, work_q};
    assign prod_fix_s = neg_q_q ? neg_2w(prod_s) : prod_s;
    assign quo_fix_s  = neg_q_q ? neg_w(work_q) : work_q;
    assign rem_fix_s  = neg_r_q ? neg_w(acc_q) : acc_q;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= ZERO_W;
            lo_q     <= ZERO_W;
            acc_q    <= ZERO_W;
            work_q   <= ZERO_W;
            mcand_q  <= ZERO_W;
            cnt_q    <= CNT_ZERO;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            work_q   <= work_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = div_zero_s ? ST_ZDIV : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // cnt_q == 1 means this edge performs the last step
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            ST_ZDIV: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered handshake outputs: busy follows the next state, done pulses on leaving FIX/ZDIV
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_FIX) || (state_q == ST_ZDIV);
    end

    // Datapath: operand capture, iteration steps, write-back and MTHI/MTLO
    always_comb begin
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        work_d   = work_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // start takes priority; any simultaneous mthi/mtlo is dropped
                    is_div_d = op[1];
                    neg_q_d  = a_neg_s ^ b_neg_s;
                    neg_r_d  = a_neg_s;
                    acc_d    = ZERO_W;
                    work_d   = a_mag_s;
                    mcand_d  = b_mag_s;
                    cnt_d    = CNT_LOAD;
                    dbz_d    = 1'b0;
                end else begin
                    hi_d = mthi ? wdata : hi_q;
                    lo_d = mtlo ? wdata : lo_q;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (is_div_q) begin
                    acc_d  = borrow_s ? rem_sh_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], ~borrow_s};
                end else begin
                    acc_d  = sum_s[WIDTH:1];
                    work_d = {sum_s[0], work_q[WIDTH-1:1]};
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end else begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end
            end
            ST_ZDIV: begin
                dbz_d = 1'b1;
            end
            default: begin
                dbz_d = dbz_q;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: a 32-bit and an 8-bit instance share
// the clock and reset. Expected Hi/Lo/flag values are pushed when an operation
// is started, then popped and compared by a monitor whenever done pulses.
module tb_hilo_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start32, mthi32, mtlo32, busy32, done32, dbz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, wdata32, hi32, lo32;
    logic        start8, mthi8, mtlo8, busy8, done8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wdata8, hi8, lo8;

    exp_t        q32[$];
    exp_t        q8[$];
    exp_t        mon32, mon8;
    logic [31:0] mhi32, mlo32, mhi8, mlo8;
    int          n_checks = 0;
    int          n_fail   = 0;

    hilo_muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .mthi(mthi32), .mtlo(mtlo32), .wdata(wdata32), .busy(busy32), .done(done32),
        .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
    );

    hilo_muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .mthi(mthi8), .mtlo(mtlo8), .wdata(wdata8), .busy(busy8), .done(done8),
        .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model on 64-bit integers for a w-bit unit
    function automatic exp_t model(input int w, input logic [1:0] op, input logic [31:0] a_in,
                                   input logic [31:0] b_in, input logic [31:0] hi_old,
                                   input logic [31:0] lo_old, input string tag);
        exp_t        e;
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a_in} & mask;
        ub   = {32'd0, b_in} & mask;
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        e.tag = tag;
        e.dbz = 1'b0;
        e.hi  = hi_old;
        e.lo  = lo_old;
        case (op)
            2'b00, 2'b01: begin
                p    = (op == 2'b00) ? 64'(sa * sb) : ua * ub;
                e.lo = 32'(p & mask);
                e.hi = 32'((p >> w) & mask);
            end
            default: begin
                if (ub == 64'd0) begin
                    e.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    q    = sa / sb;
                    r    = sa % sb;
                    e.lo = 32'(64'(q) & mask);
                    e.hi = 32'(64'(r) & mask);
                end else begin
                    e.lo = 32'(ua / ub);
                    e.hi = 32'(ua % ub);
                end
            end
        endcase
        return e;
    endfunction

    // Scoreboard monitors: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                check("done32_unexpected", 64'(done32), 64'd0);
            end else begin
                mon32 = q32.pop_front();
                check({mon32.tag, ".hi"}, 64'(hi32), 64'(mon32.hi));
                check({mon32.tag, ".lo"}, 64'(lo32), 64'(mon32.lo));
                check({mon32.tag, ".dbz"}, 64'(dbz32), 64'(mon32.dbz));
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", 64'(done8), 64'd0);
            end else begin
                mon8 = q8.pop_front();
                check({mon8.tag, ".hi"}, 64'(hi8), 64'(mon8.hi));
                check({mon8.tag, ".lo"}, 64'(lo8), 64'(mon8.lo));
                check({mon8.tag, ".dbz"}, 64'(dbz8), 64'(mon8.dbz));
            end
        end
    end

    // Start one operation at a negedge and wait for done; optionally also pulse mthi/mtlo with start
    task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit with_mt, input string tag);
        exp_t e;
        int   w, lat, bcnt, exp_lat;
        bit   zd;
        w       = w8 ? 8 : 32;
        zd      = w8 ? (b[7:0] == 8'd0) : (b == 32'd0);
        exp_lat = (op[1] && zd) ? 1 : w + 1;
        e = model(w, op, a, b, w8 ? mhi8 : mhi32, w8 ? mlo8 : mlo32, tag);
        if (w8) begin
            q8.push_back(e);
            mhi8 = e.hi; mlo8 = e.lo;
            op8 = op; a8 = a[7:0]; b8 = b[7:0];
            mthi8 = with_mt; mtlo8 = with_mt; wdata8 = 8'h34;
            start8 = 1'b1;
        end else begin
            q32.push_back(e);
            mhi32 = e.hi; mlo32 = e.lo;
            op32 = op; a32 = a; b32 = b;
            mthi32 = with_mt; mtlo32 = with_mt; wdata32 = 32'h0000_1234;
            start32 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8 = 1'b0; mthi8 = 1'b0; mtlo8 = 1'b0;
        start32 = 1'b0; mthi32 = 1'b0; mtlo32 = 1'b0;
        // Operands wander after acceptance; the result must not care
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        lat  = -1;
        bcnt = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, ".dbz_cleared"}, 64'(w8 ? dbz8 : dbz32), 64'd0);
            if ((w8 ? busy8 : busy32) == 1'b1) bcnt++;
            if ((w8 ? done8 : done32) == 1'b1) begin
                lat = c - 1;
                break;
            end
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    endtask

    initial begin
        exp_t e;
        int   lat, ndone;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int   sel;

        reset = 1'b1;
        start32 = 1'b0; mthi32 = 1'b0; mtlo32 = 1'b0; op32 = 2'b00;
        a32 = 32'd0; b32 = 32'd0; wdata32 = 32'd0;
        start8 = 1'b0; mthi8 = 1'b0; mtlo8 = 1'b0; op8 = 2'b00;
        a8 = 8'd0; b8 = 8'd0; wdata8 = 8'd0;
        mhi32 = 32'd0; mlo32 = 32'd0; mhi8 = 32'd0; mlo8 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.hi", 64'(hi32), 64'd0);
        check("reset.lo", 64'(lo32), 64'd0);
        check("reset.busy", 64'(busy32), 64'd0);
        check("reset.done", 64'(done32), 64'd0);
        check("reset.dbz", 64'(dbz32), 64'd0);
        check("reset8.hilo", {32'(hi8), 32'(lo8)}, 64'd0);
        reset = 1'b0;

        // Signed/unsigned multiply and divide, including the MIN/-1 wrap
        run_op(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_m3x5");
        run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(1'b0, 2'b11, 32'd100, 32'd7, 1'b0, "divu_100_7");
        run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        run_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1");

        // mthi+mtlo together write both, then mtlo alone
        mthi32 = 1'b1; mtlo32 = 1'b1; wdata32 = 32'h0000_AAAA;
        @(negedge clk);
        mthi32 = 1'b0; wdata32 = 32'h0000_5555;
        check("mthi_mtlo.hi", 64'(hi32), 64'h0000_AAAA);
        check("mthi_mtlo.lo", 64'(lo32), 64'h0000_AAAA);
        @(negedge clk);
        mtlo32 = 1'b0;
        check("mtlo.hi", 64'(hi32), 64'h0000_AAAA);
        check("mtlo.lo", 64'(lo32), 64'h0000_5555);
        mhi32 = 32'h0000_AAAA; mlo32 = 32'h0000_5555;

        // Zero divisor with mthi/mtlo on the start cycle: writes dropped, flag set
        run_op(1'b0, 2'b10, 32'd7, 32'd0, 1'b1, "div_zero");
        check("div_zero.flag_sticky", 64'(dbz32), 64'd1);
        run_op(1'b0, 2'b11, 32'd100, 32'd7, 1'b0, "divu_after_zero");

        // MULT 6*7 with start/mthi/mtlo pulsed while busy
        e = model(32, 2'b00, 32'd6, 32'd7, mhi32, mlo32, "mult_disturbed");
        q32.push_back(e); mhi32 = e.hi; mlo32 = e.lo;
        op32 = 2'b00; a32 = 32'd6; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 10) begin
                start32 = 1'b1; op32 = 2'b11; a32 = 32'd9; b32 = 32'd0;
                mthi32 = 1'b1; mtlo32 = 1'b1; wdata32 = 32'hDEAD_BEEF;
            end else begin
                start32 = 1'b0; mthi32 = 1'b0; mtlo32 = 1'b0;
            end
            if (done32) begin
                lat = c - 1;
                break;
            end
        end
        check("mult_disturbed.latency", 64'(lat), 64'd33);

        // Reset in the middle of a MULT: no result, no done
        op32 = 2'b00; a32 = 32'd6; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            reset = (c == 15);
            if (c == 16) begin
                check("reset_mid.hi", 64'(hi32), 64'd0);
                check("reset_mid.lo", 64'(lo32), 64'd0);
                check("reset_mid.busy", 64'(busy32), 64'd0);
            end
            if (done32) ndone++;
        end
        check("reset_mid.no_done", 64'(ndone), 64'd0);
        mhi32 = 32'd0; mlo32 = 32'd0; mhi8 = 32'd0; mlo8 = 32'd0;

        // 8-bit instance: MIN*MIN, then a random regression (back-to-back starts)
        run_op(1'b1, 2'b00, 32'h80, 32'h80, 1'b0, "w8_mult_min");
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            ra  = (sel == 1) ? 32'h80 : $urandom;
            rb  = (sel == 0) ? 32'h0 : ((sel == 1) ? 32'hFF : $urandom);
            run_op(1'b1, rop, ra, rb, 1'b0, $sformatf("w8_rand%0d", i));
        end

        // 32-bit random regression
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            ra  = (sel == 1) ? 32'h8000_0000 : $urandom;
            rb  = (sel == 0) ? 32'h0 : ((sel == 1) ? 32'hFFFF_FFFF : ((sel == 2) ? 32'($urandom_range(1, 20)) : $urandom));
            run_op(1'b0, rop, ra, rb, 1'b0, $sformatf("w32_rand%0d", i));
        end

        repeat (3) @(negedge clk);
        check("scoreboard32_drained", 64'(q32.size()), 64'd0);
        check("scoreboard8_drained", 64'(q8.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
